// File: rtl/game_pkg.sv
// Shared screen geometry and coordinate types for the sprite/projectile datapath.
package game_pkg;
   localparam int COORD_W       = 12;
   localparam int VER_PIXELS    = 768;
   localparam int SCREEN_HEIGHT = VER_PIXELS;

   typedef logic [COORD_W-1:0] coord_t;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/projectile_slot.sv
// One projectile: x/y/active registers with spawn load, per-frame move and hit clear.
// Priority is spawn > clear > move; active_next is exported so the parent can count free slots.
module projectile_slot
   import game_pkg::*;
#(
   parameter int   CW    = 12,
   parameter int   SPEED = 6,
   parameter int   SCR_H = 768,
   parameter dir_e DIR   = DIR_UP
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_tick,
   input  logic          spawn,
   input  logic          clear,
   input  logic [CW-1:0] spawn_x,
   input  logic [CW-1:0] spawn_y,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          active,
   output logic          active_next
);
   localparam logic [CW:0] SPD = (CW+1)'(SPEED);
   localparam logic [CW:0] SCR = (CW+1)'(SCR_H);

   logic [CW:0] y_ext;
   logic        leaves;
   logic        moving;

   // One extra bit on the compare so the edge test can never wrap.
   assign y_ext  = {1'b0, y};
   assign leaves = (DIR == DIR_UP) ? (y_ext < SPD) : ((y_ext + SPD) >= SCR);
   assign moving = !spawn && !clear && frame_tick && active;

   always_comb begin
      active_next = active;
      if (rst)
         active_next = 1'b0;
      else if (spawn)
         active_next = 1'b1;
      else if (clear)
         active_next = 1'b0;
      else if (moving && leaves)
         active_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x      <= '0;
         y      <= '0;
         active <= 1'b0;
      end else begin
         active <= active_next;
         if (spawn) begin
            x <= spawn_x;
            y <= spawn_y;
         end else if (moving && !leaves) begin
            y <= (DIR == DIR_UP) ? (y - SPD[CW-1:0]) : (y + SPD[CW-1:0]);
         end
      end
   end
endmodule

// File: rtl/projectile_pool_ctl.sv
// Pool of NUM_SLOTS projectiles: fire edge detect, cooldown, lowest-free allocation and status pulses.
// A fire edge spawns one cycle later into the lowest slot that was inactive at the start of the cycle.
module projectile_pool_ctl #(
   parameter int NUM_SLOTS       = 4,
   parameter int COORD_W         = game_pkg::COORD_W,
   parameter int BULLET_WIDTH    = 16,
   parameter int BULLET_HEIGHT   = 32,
   parameter int SHOOTER_WIDTH   = 64,
   parameter int SHOOTER_HEIGHT  = 64,
   parameter int SPEED           = 6,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int SCREEN_HEIGHT   = game_pkg::SCREEN_HEIGHT,
   parameter int DIR_DOWN        = 0
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             frame_tick,
   input  logic                             shoot,
   input  logic [COORD_W-1:0]               origin_x,
   input  logic [COORD_W-1:0]               origin_y,
   input  logic [NUM_SLOTS-1:0]             hit_clear,
   output logic [NUM_SLOTS*COORD_W-1:0]     bullet_x,
   output logic [NUM_SLOTS*COORD_W-1:0]     bullet_y,
   output logic [NUM_SLOTS-1:0]             bullet_active,
   output logic                             fired,
   output logic                             denied,
   output logic [$clog2(NUM_SLOTS+1)-1:0]   free_count
);
   localparam int FC_W = $clog2(NUM_SLOTS+1);
   localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES+1) : 1;
   localparam logic [COORD_W-1:0] X_OFF = COORD_W'((SHOOTER_WIDTH - BULLET_WIDTH) / 2);
   localparam logic [COORD_W-1:0] BH    = COORD_W'(BULLET_HEIGHT);
   localparam logic [COORD_W-1:0] SH    = COORD_W'(SHOOTER_HEIGHT);

   logic                 shoot_q;
   logic [CD_W-1:0]      cooldown;
   logic                 req;
   logic                 accept;
   logic                 found;
   logic                 underflow;
   logic [NUM_SLOTS-1:0] spawn_sel;
   logic [NUM_SLOTS-1:0] spawn_vec;
   logic [NUM_SLOTS-1:0] active_next;
   logic [FC_W-1:0]      free_next;
   logic [COORD_W-1:0]   spawn_x;
   logic [COORD_W-1:0]   spawn_y;

   assign req       = shoot && !shoot_q;
   assign spawn_x   = origin_x + X_OFF;
   assign spawn_y   = (DIR_DOWN != 0) ? (origin_y + SH) : (origin_y - BH);
   assign underflow = (DIR_DOWN == 0) && (origin_y < BH);
   assign accept    = req && (cooldown == '0) && found && !underflow;
   assign spawn_vec = accept ? spawn_sel : '0;

   // Allocation looks only at the registered mask, so a slot cleared this cycle is not reused yet.
   always_comb begin
      spawn_sel = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!bullet_active[i] && !found) begin
            spawn_sel[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   always_comb begin
      free_next = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!active_next[i])
            free_next = free_next + FC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shoot_q    <= 1'b0;
         cooldown   <= '0;
         fired      <= 1'b0;
         denied     <= 1'b0;
         free_count <= FC_W'(NUM_SLOTS);
      end else begin
         shoot_q    <= shoot;
         fired      <= accept;
         denied     <= req && !accept;
         free_count <= free_next;
         if (accept)
            cooldown <= CD_W'(COOLDOWN_FRAMES);
         else if (frame_tick && (cooldown != '0))
            cooldown <= cooldown - 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      projectile_slot #(
         .CW    (COORD_W),
         .SPEED (SPEED),
         .SCR_H (SCREEN_HEIGHT),
         .DIR   ((DIR_DOWN != 0) ? game_pkg::DIR_DOWN : game_pkg::DIR_UP)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .frame_tick  (frame_tick),
         .spawn       (spawn_vec[i]),
         .clear       (hit_clear[i]),
         .spawn_x     (spawn_x),
         .spawn_y     (spawn_y),
         .x           (bullet_x[i*COORD_W +: COORD_W]),
         .y           (bullet_y[i*COORD_W +: COORD_W]),
         .active      (bullet_active[i]),
         .active_next (active_next[i])
      );
   end
endmodule
